sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_if.sv | 33 +++
 rtl/sram_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_if
// Description : Switch-side request bus of the SRAM controller.
//               master : drives ce_i/we_i/addr_i/sel_i/data_i,
//                        receives data_o/stall_o
//               slave  : the controller side of the same bus
//   ce_i    request valid           we_i   1=write, 0=read
//   addr_i  byte address [31:0]     sel_i  byte-lane enables [3:0]
//   data_i  write data [31:0]       data_o read data [31:0]
//   stall_o 1 = request not yet complete, initiator holds its request
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stall_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Single-access asynchronous SRAM controller. A request on the
//               switch-side bus is latched in IDLE, the external strobes are
//               held for WAIT_CYCLES cycles, and the request completes in a
//               one-cycle DONE state.
// Ports       :
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   bus          sram_ctrl_if.slave switch-side request bus
//   ram_addr_o   external SRAM word address [19:0]
//   ram_data_o   external write data [31:0]
//   ram_data_i   external read data [31:0]
//   ram_data_oe  1 = drive the external data bus
//   ram_ce_n / ram_oe_n / ram_we_n / ram_be_n[3:0]  active-low strobes
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2     // strobe hold time per access, 1..15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sram_ctrl_if.slave       bus,
    output logic [19:0]      ram_addr_o,
    output logic [31:0]      ram_data_o,
    input  wire logic [31:0] ram_data_i,
    output logic             ram_data_oe,
    output logic             ram_ce_n,
    output logic             ram_oe_n,
    output logic             ram_we_n,
    output logic [3:0]       ram_be_n
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [19:0] addr_q,  addr_d;
    logic [3:0]  sel_q,   sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] lane_mask;

    // Byte address bits outside [21:2] carry no meaning for a word SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[31:22], bus.addr_i[1:0]};

    assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 20'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The direction of the access is carried by the
    // READ/WRITE state itself, so no separate write-enable register is kept.
    // Once an access has started it always runs to DONE: dropping ce_i only
    // means nobody looks at the result.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.ce_i) begin
                    addr_d  = bus.addr_i[21:2];
                    sel_d   = bus.sel_i;
                    wdata_d = bus.data_i;
                    if (bus.we_i) begin
                        // A write with no lanes selected has nothing to do.
                        if (bus.sel_i == 4'b0000) begin
                            state_d = DONE;
                        end else begin
                            state_d = WRITE;
                            cnt_d   = CNT_LOAD;
                        end
                    end else begin
                        state_d = READ;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    // Capture on the last strobed cycle; read data is held
                    // here until the next read completes.
                    rdata_d = ram_data_i & lane_mask;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Always pass through IDLE, so a ce_i still high here is not
                // mistaken for a fresh request.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the state register, so the asynchronous
    // reset releases every strobe immediately without waiting for a clock.
    // oe_n and data_oe are only ever asserted in different states, which
    // keeps the external data bus free of contention.
    // ------------------------------------------------------------------
    always_comb begin
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_be_n    = 4'hF;
        ram_data_oe = 1'b0;

        case (state_q)
            READ: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = ~sel_q;
            end
            WRITE: begin
                ram_ce_n    = 1'b0;
                ram_we_n    = 1'b0;
                ram_be_n    = ~sel_q;
                ram_data_oe = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign bus.data_o  = rdata_q;
    assign bus.stall_o = bus.ce_i && (state_q != DONE);

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Scoreboard bench for sram_ctrl with a behavioural SRAM.
//               Stimulus pushes expected external accesses and expected
//               completions; two monitors pop and compare them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if bus ();

    logic [19:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        ram_data_oe;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [3:0]  ram_be_n;

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i),
        .ram_data_oe (ram_data_oe),
        .ram_ce_n    (ram_ce_n),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n),
        .ram_be_n    (ram_be_n)
    );

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem [0:1048575];

    assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr_o] : 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            mem[20'h00008] <= 32'hA5A5_5A5A;
        end else if (!ram_ce_n && !ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!ram_be_n[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic [31:0] wd;
        int          len;
    } ext_t;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          stall;
    } resp_t;

    ext_t  exp_ext  [$];
    resp_t exp_resp [$];

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_ext(input logic we, input logic [19:0] addr,
                                     input logic [3:0] be_n, input logic [31:0] wd, input int len);
        ext_t e;
        e.we = we; e.addr = addr; e.be_n = be_n; e.wd = wd; e.len = len;
        exp_ext.push_back(e);
    endfunction

    function automatic void push_resp(input logic rd, input logic [31:0] data, input int stall);
        resp_t r;
        r.rd = rd; r.data = data; r.stall = stall;
        exp_resp.push_back(r);
    endfunction

    // External access monitor: one record per contiguous ram_ce_n low burst.
    initial begin
        bit          in_acc = 1'b0;
        int          len    = 0;
        logic        a_we   = 1'b0;
        logic [19:0] a_addr = '0;
        logic [3:0]  a_be   = '0;
        logic [31:0] a_wd   = '0;
        ext_t        e;
        forever begin
            @(negedge clk);
            // Strobes must never fight over the data bus.
            check("oe_vs_data_oe", {31'd0, ram_data_oe && !ram_oe_n}, 32'd0);
            if (!rst) begin
                in_acc = 1'b0;
            end else if (!ram_ce_n) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    len    = 1;
                    a_we   = !ram_we_n;
                    a_addr = ram_addr_o;
                    a_be   = ram_be_n;
                    a_wd   = ram_data_o;
                    check("access_strobe_dir", {31'd0, ram_we_n ^ ram_oe_n}, 32'd1);
                    check("access_data_oe", {31'd0, ram_data_oe}, {31'd0, !ram_we_n});
                end else begin
                    len++;
                end
            end else if (in_acc) begin
                in_acc = 1'b0;
                if (exp_ext.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access: got addr %h expected no access", a_addr);
                end else begin
                    e = exp_ext.pop_front();
                    check("access_we",   {31'd0, a_we}, {31'd0, e.we});
                    check("access_addr", {12'd0, a_addr}, {12'd0, e.addr});
                    check("access_be_n", {28'd0, a_be}, {28'd0, e.be_n});
                    check("access_len",  32'(len), 32'(e.len));
                    if (e.we) check("access_wdata", a_wd, e.wd);
                end
            end
        end
    end

    // Completion monitor: a request completes when stall_o falls while ce_i
    // is still held; the stall run length is the observed latency.
    initial begin
        int    run = 0;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else if (bus.ce_i && bus.stall_o) begin
                run++;
            end else if (bus.ce_i && !bus.stall_o && run > 0) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_completion: got stall run %0d expected none", run);
                end else begin
                    r = exp_resp.pop_front();
                    check("stall_cycles", 32'(run), 32'(r.stall));
                    if (r.rd) check("read_data", bus.data_o, r.data);
                end
                run = 0;
            end else begin
                run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data);
        @(posedge clk); #2;
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.sel_i  = sel;
        bus.data_i = data;
        bus.ce_i   = 1'b1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!bus.stall_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got stall_o stuck 1 expected completion");
        end
    endtask

    task automatic release_ce();
        @(posedge clk); #2;
        bus.ce_i = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data);
        issue(we, addr, sel, data);
        wait_done();
        release_ce();
    endtask

    initial begin
        int gap;
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ce_n",     {31'd0, ram_ce_n}, 32'd1);
        check("rst_oe_n",     {31'd0, ram_oe_n}, 32'd1);
        check("rst_we_n",     {31'd0, ram_we_n}, 32'd1);
        check("rst_be_n",     {28'd0, ram_be_n}, 32'hF);
        check("rst_data_oe",  {31'd0, ram_data_oe}, 32'd0);
        check("rst_ram_addr", {12'd0, ram_addr_o}, 32'd0);
        check("rst_ram_data", ram_data_o, 32'd0);
        check("rst_data_o",   bus.data_o, 32'd0);
        check("rst_stall",    {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full write: word address 4, we_n low 2 cycles, stall 3 cycles.
        push_ext(1'b1, 20'h00004, 4'h0, 32'hDEADBEEF, 2);
        push_resp(1'b0, 32'h0, 3);
        xact(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);

        // Half-word read, upper lanes forced to zero.
        push_ext(1'b0, 20'h00004, 4'hC, 32'h0, 2);
        push_resp(1'b1, 32'h0000BEEF, 3);
        xact(1'b0, 32'h0000_0010, 4'b0011, 32'h0);

        // Write with no lanes: no strobes, single stall cycle.
        push_resp(1'b0, 32'h0, 1);
        xact(1'b1, 32'h0000_0020, 4'b0000, 32'h1234_5678);

        // ce_i dropped after accept: access still completes.
        push_ext(1'b1, 20'h0000C, 4'h0, 32'hCAFEF00D, 2);
        issue(1'b1, 32'h0000_0030, 4'hF, 32'hCAFEF00D);
        release_ce();
        repeat (6) @(posedge clk);
        push_ext(1'b0, 20'h0000C, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hCAFEF00D, 3);
        xact(1'b0, 32'h0000_0030, 4'hF, 32'h0);

        // Untouched by the lane-less write.
        push_ext(1'b0, 20'h00008, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hA5A5_5A5A, 3);
        xact(1'b0, 32'h0000_0020, 4'hF, 32'h0);

        // Reset in the middle of a write.
        issue(1'b1, 32'h0000_0040, 4'hF, 32'h1111_2222);
        @(posedge clk); #1;
        check("midwrite_we_n", {31'd0, ram_we_n}, 32'd0);
        #1;
        rst = 1'b0;
        bus.ce_i = 1'b0;
        #1;
        check("arst_we_n",     {31'd0, ram_we_n}, 32'd1);
        check("arst_ce_n",     {31'd0, ram_ce_n}, 32'd1);
        check("arst_oe_n",     {31'd0, ram_oe_n}, 32'd1);
        check("arst_be_n",     {28'd0, ram_be_n}, 32'hF);
        check("arst_data_oe",  {31'd0, ram_data_oe}, 32'd0);
        check("arst_ram_addr", {12'd0, ram_addr_o}, 32'd0);
        check("arst_data_o",   bus.data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_ext(1'b0, 20'h00004, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hDEADBEEF, 3);
        xact(1'b0, 32'h0000_0010, 4'hF, 32'h0);

        // Two reads with ce_i held high: one IDLE gap between accesses.
        push_ext(1'b0, 20'h00004, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hDEADBEEF, 3);
        push_ext(1'b0, 20'h0000C, 4'h3, 32'h0, 2);
        push_resp(1'b1, 32'hCAFE0000, 3);
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        wait_done();
        gap = 1;
        @(posedge clk); #2;
        bus.addr_i = 32'h0000_0030;
        bus.sel_i  = 4'b1100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_ce_n) gap++;
            else break;
        end
        check("b2b_ce_gap", 32'(gap), 32'd2);
        wait_done();
        release_ce();

        repeat (5) @(negedge clk);
        check("ext_queue_empty",  32'(exp_ext.size()), 32'd0);
        check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
